// File: rtl/convertor_bcd_secvential_pkg.sv
// Shared display constants for the sequential binary-to-BCD converter:
// FSM encodings, add-3 correction constants and the default saturation limit.
package convertor_bcd_secvential_pkg;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_SHIFT = 2'b01;
    localparam logic [1:0] ST_DONE  = 2'b10;

    localparam logic [3:0] BCD_ADD_PRAG = 4'd5;
    localparam logic [3:0] BCD_CORECTIE = 4'd3;

    localparam int unsigned VALOARE_MAX_IMPLICIT = 99;

endpackage

// File: rtl/convertor_bcd_secvential_if.sv
// Start/done handshake and digit bus between the counter logic (master)
// and the BCD converter (slave).
interface convertor_bcd_secvential_if #(
    parameter int unsigned LATIME = 7
);
    logic              start;
    logic [LATIME-1:0] valoare;
    logic [3:0]        cifra_zeci;
    logic [3:0]        cifra_unitati;
    logic              depasire;
    logic              ocupat;
    logic              gata;

    modport master (
        output start, valoare,
        input  cifra_zeci, cifra_unitati, depasire, ocupat, gata
    );

    modport slave (
        input  start, valoare,
        output cifra_zeci, cifra_unitati, depasire, ocupat, gata
    );
endinterface

// File: rtl/convertor_bcd_secvential_corectie_add3.sv
// Double-dabble nibble correction: values of 5 or more get 3 added
// so the following left shift carries correctly into the next BCD digit.
module corectie_add3
    import convertor_bcd_secvential_pkg::*;
(
    input  logic [3:0] intrare,
    output logic [3:0] iesire
);

    always_comb begin
        iesire = intrare;
        if (intrare >= BCD_ADD_PRAG)
            iesire = intrare + BCD_CORECTIE;
    end

endmodule

// File: rtl/convertor_bcd_secvential.sv
// Sequential shift-and-add-3 binary to two-digit BCD converter with saturation
// to VALOARE_MAX, start/done handshake and results held until the next conversion.
module convertor_bcd_secvential
    import convertor_bcd_secvential_pkg::*;
#(
    parameter int unsigned LATIME      = 7,
    parameter int unsigned VALOARE_MAX = VALOARE_MAX_IMPLICIT
) (
    input  logic                        clock,
    input  logic                        reset,
    convertor_bcd_secvential_if.slave   bus
);

    localparam int unsigned CW = $clog2(LATIME + 1);

    logic [1:0]        stare;
    logic [LATIME-1:0] bin_reg;
    logic [7:0]        bcd_reg;
    logic [CW-1:0]     contor;
    logic              ovf;

    logic [3:0]        zeci_q;
    logic [3:0]        unitati_q;
    logic              depasire_q;
    logic              ocupat_q;
    logic              gata_q;

    logic [3:0]         zeci_cor;
    logic [3:0]         unitati_cor;
    logic               depaseste;
    logic [LATIME-1:0]  saturat;
    logic [LATIME+7:0]  deplasat;

    corectie_add3 u_corectie_zeci (
        .intrare (bcd_reg[7:4]),
        .iesire  (zeci_cor)
    );

    corectie_add3 u_corectie_unitati (
        .intrare (bcd_reg[3:0]),
        .iesire  (unitati_cor)
    );

    always_comb begin
        depaseste = (32'(bus.valoare) > VALOARE_MAX);
        saturat   = depaseste ? LATIME'(VALOARE_MAX) : bus.valoare;
        // bin MSB moves into the BCD LSB; the top tens bit is dropped (result <= 99)
        deplasat  = {zeci_cor, unitati_cor, bin_reg} << 1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stare      <= ST_IDLE;
            bin_reg    <= '0;
            bcd_reg    <= '0;
            contor     <= '0;
            ovf        <= 1'b0;
            zeci_q     <= '0;
            unitati_q  <= '0;
            depasire_q <= 1'b0;
            ocupat_q   <= 1'b0;
            gata_q     <= 1'b0;
        end else begin
            gata_q <= 1'b0;
            case (stare)
                ST_IDLE: begin
                    if (bus.start) begin
                        bin_reg  <= saturat;
                        bcd_reg  <= '0;
                        contor   <= CW'(LATIME);
                        ovf      <= depaseste;
                        ocupat_q <= 1'b1;
                        stare    <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    bcd_reg <= deplasat[LATIME+7:LATIME];
                    bin_reg <= deplasat[LATIME-1:0];
                    contor  <= contor - CW'(1);
                    if (contor == CW'(1))
                        stare <= ST_DONE;
                end
                ST_DONE: begin
                    zeci_q     <= bcd_reg[7:4];
                    unitati_q  <= bcd_reg[3:0];
                    depasire_q <= ovf;
                    gata_q     <= 1'b1;
                    ocupat_q   <= 1'b0;
                    stare      <= ST_IDLE;
                end
                default: stare <= ST_IDLE;
            endcase
        end
    end

    assign bus.cifra_zeci    = zeci_q;
    assign bus.cifra_unitati = unitati_q;
    assign bus.depasire      = depasire_q;
    assign bus.ocupat        = ocupat_q;
    assign bus.gata          = gata_q;

endmodule

// File: tb/tb_convertor_bcd_secvential.sv
// Directed + sweep bench for convertor_bcd_secvential: expected digits and the
// start edge are queued on each start, popped and compared on every gata pulse.
module tb_convertor_bcd_secvential;

    localparam int unsigned LAT  = 7;
    localparam int unsigned VMAX = 99;

    typedef struct {
        logic [3:0] z;
        logic [3:0] u;
        logic       o;
        int         k;
    } asteptat_t;

    logic clock;
    logic reset;
    int   cyc;
    int   errors;
    int   checks;
    logic prev_gata;
    logic [3:0] last_z;
    logic [3:0] last_u;
    logic       last_o;
    asteptat_t  sb[$];

    convertor_bcd_secvential_if #(.LATIME(LAT)) bus ();

    convertor_bcd_secvential #(.LATIME(LAT), .VALOARE_MAX(VMAX)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic void push(input int v, input int k);
        asteptat_t e;
        int s;
        s   = (v > VMAX) ? VMAX : v;
        e.z = 4'(s / 10);
        e.u = 4'(s % 10);
        e.o = (v > VMAX);
        e.k = k;
        sb.push_back(e);
    endfunction

    // Scoreboard monitor: sampled 1 time unit after each rising edge
    always @(posedge clock) begin
        asteptat_t e;
        cyc++;
        #1;
        if (bus.gata === 1'b1) begin
            check("gata_width", {31'd0, prev_gata}, 0);
            if (sb.size() == 0) begin
                check("spurious_gata", 1, 0);
            end else begin
                e = sb.pop_front();
                check("zeci",    {28'd0, bus.cifra_zeci},    {28'd0, e.z});
                check("unitati", {28'd0, bus.cifra_unitati}, {28'd0, e.u});
                check("depasire",{31'd0, bus.depasire},      {31'd0, e.o});
                check("latency", cyc - e.k, LAT + 1);
                check("ocupat_at_gata", {31'd0, bus.ocupat}, 0);
                last_z = e.z;
                last_u = e.u;
                last_o = e.o;
            end
        end else if (reset === 1'b0) begin
            check("hold_zeci",     {28'd0, bus.cifra_zeci},    {28'd0, last_z});
            check("hold_unitati",  {28'd0, bus.cifra_unitati}, {28'd0, last_u});
            check("hold_depasire", {31'd0, bus.depasire},      {31'd0, last_o});
        end
        prev_gata = bus.gata;
    end

    task automatic run_conv(input int v);
        int busy;
        busy = 0;
        @(negedge clock);
        bus.start   = 1'b1;
        bus.valoare = LAT'(v);
        push(v, cyc + 1);
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            bus.start = 1'b0;
            if (bus.ocupat === 1'b1) busy++;
        end
        check("ocupat_cycles", busy, LAT + 1);
        check("sb_drained", sb.size(), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        errors = 0; checks = 0; cyc = 0;
        prev_gata = 1'b0;
        last_z = '0; last_u = '0; last_o = 1'b0;
        reset = 1'b1;
        bus.start = 1'b0;
        bus.valoare = '0;
        repeat (2) @(negedge clock);
        check("rst_zeci",     {28'd0, bus.cifra_zeci},    0);
        check("rst_unitati",  {28'd0, bus.cifra_unitati}, 0);
        check("rst_depasire", {31'd0, bus.depasire},      0);
        check("rst_ocupat",   {31'd0, bus.ocupat},        0);
        check("rst_gata",     {31'd0, bus.gata},          0);
        reset = 1'b0;
        @(negedge clock);

        run_conv(57);
        run_conv(0);
        run_conv(99);
        run_conv(120);
        run_conv(127);
        run_conv(42);

        // start re-asserted while busy must be ignored
        @(negedge clock);
        bus.start = 1'b1; bus.valoare = 7'd31;
        push(31, cyc + 1);
        @(negedge clock);
        bus.start = 1'b0;
        repeat (2) @(negedge clock);
        bus.start = 1'b1; bus.valoare = 7'd64;
        @(negedge clock);
        bus.start = 1'b0; bus.valoare = '0;
        repeat (10) @(negedge clock);
        check("busy_ignored_drained", sb.size(), 0);

        // back-to-back: start raised in the gata cycle
        @(negedge clock);
        bus.start = 1'b1; bus.valoare = 7'd25;
        push(25, cyc + 1);
        @(negedge clock);
        bus.start = 1'b0;
        w = 0;
        while (bus.gata !== 1'b1 && w < 20) begin
            @(negedge clock);
            w++;
        end
        check("gata_seen", {31'd0, bus.gata}, 1);
        bus.start = 1'b1; bus.valoare = 7'd10;
        push(10, cyc + 1);
        @(negedge clock);
        bus.start = 1'b0;
        repeat (12) @(negedge clock);
        check("b2b_drained", sb.size(), 0);

        // asynchronous reset in the middle of SHIFT
        @(negedge clock);
        bus.start = 1'b1; bus.valoare = 7'd88;
        push(88, cyc + 1);
        @(negedge clock);
        bus.start = 1'b0;
        repeat (2) @(negedge clock);
        #2;
        sb.delete();
        last_z = '0; last_u = '0; last_o = 1'b0;
        reset = 1'b1;
        #1;
        check("arst_zeci",    {28'd0, bus.cifra_zeci},    0);
        check("arst_unitati", {28'd0, bus.cifra_unitati}, 0);
        check("arst_ocupat",  {31'd0, bus.ocupat},        0);
        check("arst_gata",    {31'd0, bus.gata},          0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        repeat (12) @(negedge clock);
        run_conv(88);

        for (int v = 0; v < 128; v++)
            run_conv(v);

        repeat (3) @(negedge clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
